// File: rtl/screen_op_sequencer_if.sv
// Bus bundle between the command path, the screen op sequencer and the character RAM.
//   op_*     : bulk operation request/accept/completion
//   hw_*     : single character write request/accept
//   busy     : bulk operation in progress
//   mem_*    : single shared RAM access port (mem_slot paces consumption)
// Modports: slave = the sequencer, master = the surrounding command path / RAM.
interface screen_op_sequencer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_code;
    logic [5:0]        op_x;
    logic [3:0]        op_y;
    logic              op_done;
    logic              busy;

    logic              hw_valid;
    logic              hw_ready;
    logic [ADDR_W-1:0] hw_addr;
    logic [7:0]        hw_data;

    logic              mem_slot;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  op_valid, op_code, op_x, op_y,
        input  hw_valid, hw_addr, hw_data,
        input  mem_slot, mem_rdata,
        output op_ready, op_done, busy,
        output hw_ready,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output op_valid, op_code, op_x, op_y,
        output hw_valid, hw_addr, hw_data,
        output mem_slot, mem_rdata,
        input  op_ready, op_done, busy,
        input  hw_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/screen_op_sequencer.sv
// Screen op sequencer: runs bulk operations (clear screen, erase to end of line,
// erase to end of screen, scroll up one line) on the COLSxROWS character buffer and
// shares the buffer's single access port with single-character host writes.
//   clk, clr : clock, asynchronous active-high reset
//   bus      : screen_op_sequencer_if.slave (op request, host write, RAM port)
// mem_* are registered; an access is consumed on an edge with mem_en && mem_slot,
// and the next access (or mem_en=0) is loaded on that same edge.
module screen_op_sequencer #(
    parameter int unsigned COLS   = 64,
    parameter int unsigned ROWS   = 16,
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic                  clk,
    input  logic                  clr,
    screen_op_sequencer_if.slave  bus
);
    localparam int unsigned       CELLS     = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ROW_SPAN  = ADDR_W'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] src_addr;

    logic              port_free;
    logic              op_free;
    logic              hw_take;
    logic              op_take;
    logic              op_bad;
    logic              consumed;
    logic [31:0]       op_x_ext;
    logic [31:0]       op_y_ext;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] start_addr;

    // The port can take a new access when idle and the current one (if any) is consumed now.
    assign port_free    = !clr && (state == S_IDLE) && (!bus.mem_en || bus.mem_slot);
    assign op_free      = port_free && !bus.hw_valid;
    assign bus.hw_ready = port_free;
    assign bus.op_ready = op_free;
    assign hw_take      = bus.hw_valid && port_free;
    assign op_take      = bus.op_valid && op_free;
    assign consumed     = bus.mem_en && bus.mem_slot;

    assign op_x_ext   = 32'(bus.op_x);
    assign op_y_ext   = 32'(bus.op_y);
    assign row_base   = ADDR_W'(op_y_ext * COLS);
    assign start_addr = row_base + ADDR_W'(bus.op_x);
    // Out-of-range start position on the erase ops completes without touching memory.
    assign op_bad     = ((bus.op_code == 2'd1) || (bus.op_code == 2'd2)) &&
                        ((op_x_ext >= COLS) || (op_y_ext >= ROWS));

    // Sequencer state, RAM port and status outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= S_IDLE;
            end_addr      <= '0;
            src_addr      <= '0;
            bus.op_done   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.op_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (consumed) begin
                        bus.mem_en <= 1'b0;
                    end
                    if (hw_take) begin
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.hw_addr;
                        bus.mem_wdata <= bus.hw_data;
                    end else if (op_take) begin
                        bus.busy <= 1'b1;
                        if (op_bad) begin
                            bus.op_done <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            case (bus.op_code)
                                2'd0: begin
                                    bus.mem_addr <= '0;
                                    end_addr     <= LAST_ADDR;
                                end
                                2'd1: begin
                                    bus.mem_addr <= start_addr;
                                    end_addr     <= row_base + ROW_SPAN;
                                end
                                2'd2: begin
                                    bus.mem_addr <= start_addr;
                                    end_addr     <= LAST_ADDR;
                                end
                                default: begin
                                    bus.mem_addr <= COLS_A;
                                    src_addr     <= COLS_A;
                                end
                            endcase
                            bus.mem_en    <= 1'b1;
                            bus.mem_we    <= (bus.op_code != 2'd3);
                            bus.mem_wdata <= BLANK;
                            state         <= (bus.op_code == 2'd3) ? S_RD : S_FILL;
                        end
                    end
                end

                S_FILL: begin
                    if (consumed) begin
                        if (bus.mem_addr == end_addr) begin
                            bus.mem_en  <= 1'b0;
                            bus.op_done <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                        end
                    end
                end

                // Read consumed: read data appears next cycle, so leave one empty cycle.
                S_RD: begin
                    if (consumed) begin
                        bus.mem_en <= 1'b0;
                        state      <= S_WR;
                    end
                end

                S_WR: begin
                    if (!bus.mem_en) begin
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= src_addr - COLS_A;
                        bus.mem_wdata <= bus.mem_rdata;
                    end else if (bus.mem_slot) begin
                        if (src_addr == LAST_ADDR) begin
                            // Copy finished: blank the bottom row without a gap.
                            bus.mem_addr  <= LAST_ROW;
                            bus.mem_wdata <= BLANK;
                            end_addr      <= LAST_ADDR;
                            state         <= S_FILL;
                        end else begin
                            src_addr     <= src_addr + ADDR_W'(1);
                            bus.mem_addr <= src_addr + ADDR_W'(1);
                            bus.mem_we   <= 1'b0;
                            state        <= S_RD;
                        end
                    end
                end

                // op_done cycle: still busy, nothing accepted until the next cycle.
                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_screen_op_sequencer.sv
// Self-checking bench for screen_op_sequencer: RAM model with half-rate slot,
// reference buffer model, expected access lists derived from the op rules.
module tb_screen_op_sequencer;
    localparam int unsigned COLS   = 64;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 10;
    localparam logic [7:0]  BLANK  = 8'h20;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic slot = 1'b0;
    logic [7:0] rdata = 8'h00;

    screen_op_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    screen_op_sequencer #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(BLANK)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_slot  = slot;
    assign bus.mem_rdata = rdata;

    logic [7:0]  ram     [CELLS];
    logic [7:0]  ref_mem [CELLS];
    logic [18:0] got_q[$];
    logic [18:0] exp_q[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // RAM: consumes the presented access on slot edges; read data valid next cycle.
    always @(posedge clk) begin
        slot <= !slot;
        if (bus.mem_en && bus.mem_slot) begin
            got_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rdata <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_hw(input logic [9:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
        ref_mem[a] = d;
    endtask

    // Expected access list and resulting buffer for one bulk op.
    task automatic model_op(input logic [1:0] code, input int x, input int y);
        int lo;
        int hi;
        lo = 0;
        hi = CELLS - 1;
        if (code == 2'd3) begin
            for (int s = COLS; s < CELLS; s++) begin
                exp_q.push_back({1'b0, 10'(s), 8'h00});
                exp_q.push_back({1'b1, 10'(s - COLS), ref_mem[s]});
                ref_mem[s - COLS] = ref_mem[s];
            end
            lo = (ROWS - 1) * COLS;
        end else if (code == 2'd1) begin
            lo = y * COLS + x;
            hi = y * COLS + COLS - 1;
        end else if (code == 2'd2) begin
            lo = y * COLS + x;
        end
        for (int a = lo; a <= hi; a++) begin
            exp_q.push_back({1'b1, 10'(a), BLANK});
            ref_mem[a] = BLANK;
        end
    endtask

    task automatic compare_queues(input string tag);
        int n;
        int unsigned e0;
        logic [18:0] g;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            g = got_q[i];
            if (!g[18]) g[7:0] = 8'h00;
            e0 = n_err;
            check($sformatf("%s_access[%0d]", tag, i), 32'(g), 32'(exp_q[i]));
            if (n_err != e0) break;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_mem(input string tag);
        int unsigned e0;
        for (int a = 0; a < CELLS; a++) begin
            e0 = n_err;
            check($sformatf("%s[%0d]", tag, a), 32'(ram[a]), 32'(ref_mem[a]));
            if (n_err != e0) break;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue_op(input logic [1:0] code, input logic [5:0] x, input logic [3:0] y);
        bit acc;
        acc = 1'b0;
        bus.op_code  = code;
        bus.op_x     = x;
        bus.op_y     = y;
        bus.op_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.op_ready;
            @(posedge clk);
            #1;
        end
        bus.op_valid = 1'b0;
        check("op_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int busy_low;
        bit seen;
        busy_low = 0;
        seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (bus.op_done)    seen = 1'b1;
            else if (!bus.busy) busy_low++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_gap"}, 32'(busy_low), 32'd0);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.op_done), 32'd0);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic hw_write(input logic [9:0] a, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        bus.hw_addr  = a;
        bus.hw_data  = d;
        bus.hw_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.hw_ready;
            @(posedge clk);
            #1;
        end
        bus.hw_valid = 1'b0;
        check("hw_accept", 32'(acc), 32'd1);
        model_hw(a, d);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] code, input logic [5:0] x, input logic [3:0] y);
        issue_op(code, x, y);
        model_op(code, int'(x), int'(y));
        wait_done(tag);
        compare_queues(tag);
        check_mem({tag, "_mem"});
    endtask

    initial begin
        int idx;
        int cyc;
        int viol;
        int dcnt;
        bit acc;
        bit seen;
        logic [9:0] a;
        logic [7:0] d;

        bus.op_valid = 1'b0;
        bus.op_code  = 2'd0;
        bus.op_x     = 6'd0;
        bus.op_y     = 4'd0;
        bus.hw_valid = 1'b0;
        bus.hw_addr  = '0;
        bus.hw_data  = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en",   32'(bus.mem_en),   32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_op_done",  32'(bus.op_done),  32'd0);
        check("rst_op_ready", 32'(bus.op_ready), 32'd0);
        check("rst_hw_ready", 32'(bus.hw_ready), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        check("idle_op_ready", 32'(bus.op_ready), 32'd1);
        check("idle_hw_ready", 32'(bus.hw_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back host writes preload addr -> addr[7:0]
        idx = 0;
        cyc = 0;
        viol = 0;
        bus.hw_addr  = '0;
        bus.hw_data  = 8'h00;
        bus.hw_valid = 1'b1;
        while (idx < CELLS && cyc < 3000) begin
            @(negedge clk);
            acc = bus.hw_ready;
            if (bus.mem_en && !bus.mem_slot && bus.hw_ready) viol++;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                model_hw(10'(idx), 8'(idx));
                idx++;
                bus.hw_addr = 10'(idx);
                bus.hw_data = 8'(idx);
            end
        end
        bus.hw_valid = 1'b0;
        check("preload_count", 32'(idx), 32'(CELLS));
        check("preload_ready_while_pending", 32'(viol), 32'd0);
        check("preload_one_per_slot", 32'(cyc <= 2 * CELLS + 4), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        compare_queues("preload");
        check_mem("preload_mem");

        // Scroll up on the preloaded buffer
        run_op("scroll", 2'd3, 6'd0, 4'd0);

        // Clear screen
        run_op("clear", 2'd0, 6'd0, 4'd0);

        // Erase to end of line near the row end
        run_op("eol_60", 2'd1, 6'd60, 4'd3);
        hw_write(10'd1023, 8'h5a);
        run_op("eol_63", 2'd1, 6'd63, 4'd15);

        // Host write and op in the same cycle: write first
        bus.hw_addr  = 10'd5;
        bus.hw_data  = 8'h41;
        bus.hw_valid = 1'b1;
        bus.op_code  = 2'd1;
        bus.op_x     = 6'd62;
        bus.op_y     = 4'd0;
        bus.op_valid = 1'b1;
        @(negedge clk);
        check("arb_hw_ready", 32'(bus.hw_ready), 32'd1);
        check("arb_op_ready", 32'(bus.op_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.hw_valid = 1'b0;
        model_hw(10'd5, 8'h41);
        run_op("arb", 2'd1, 6'd62, 4'd0);

        // Host write held during a scroll: blocked until after op_done
        issue_op(2'd3, 6'd0, 4'd0);
        model_op(2'd3, 0, 0);
        a = 10'($urandom_range(0, CELLS - 1));
        d = 8'($urandom_range(0, 255));
        bus.hw_addr  = a;
        bus.hw_data  = d;
        bus.hw_valid = 1'b1;
        viol = 0;
        seen = 1'b0;
        acc  = 1'b0;
        for (int i = 0; i < 6000 && !acc; i++) begin
            @(negedge clk);
            if (bus.busy && bus.hw_ready) viol++;
            if (bus.op_done)                seen = 1'b1;
            else if (seen && bus.hw_ready)  acc = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.hw_valid = 1'b0;
        check("scroll_hw_blocked", 32'(viol), 32'd0);
        check("scroll_hw_done_seen", 32'(seen), 32'd1);
        check("scroll_hw_accepted", 32'(acc), 32'd1);
        model_hw(a, d);
        repeat (3) @(posedge clk);
        #1;
        compare_queues("scroll_hw");
        check_mem("scroll_hw_mem");

        // Randomized ops, each preceded by a random host write
        for (int k = 0; k < 5; k++) begin
            logic [1:0] c;
            logic [5:0] x;
            logic [3:0] y;
            hw_write(10'($urandom_range(0, CELLS - 1)), 8'($urandom_range(0, 255)));
            c = 2'($urandom_range(0, 3));
            x = 6'($urandom_range(0, COLS - 1));
            y = 4'($urandom_range(0, ROWS - 1));
            run_op($sformatf("rand%0d_c%0d", k, c), c, x, y);
        end

        // Reset in the middle of a scroll
        issue_op(2'd3, 6'd0, 4'd0);
        for (int i = 0; i < 400 && got_q.size() < 100; i++) begin
            @(posedge clk);
            #1;
        end
        check("midrst_progress", 32'(got_q.size() >= 100), 32'd1);
        clr = 1'b1;
        #1;
        check("midrst_mem_en",  32'(bus.mem_en),  32'd0);
        check("midrst_busy",    32'(bus.busy),    32'd0);
        check("midrst_op_done", 32'(bus.op_done), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("midrst_op_ready", 32'(bus.op_ready), 32'd1);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.op_done || bus.busy || bus.mem_en) dcnt++;
        end
        check("midrst_quiet", 32'(dcnt), 32'd0);
        @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        run_op("clear_after_rst", 2'd0, 6'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected $finish before time limit");
        $fatal(1);
    end
endmodule

// File: doc/screen_op_sequencer.md
Name: screen_op_sequencer

Overview:
- Sequences bulk operations on the 64x16 character buffer: clear screen, erase to end of line, erase to end of screen, scroll up one line.
- Shares the buffer's single access port between these bulk operations and single-character writes from the terminal command path.
- Sits between the command decoder and the character RAM. Paced by the RAM's half-rate access slot.

Parameters:
- COLS, 64, characters per row (power of two)
- ROWS, 16, rows on screen
- ADDR_W, 10, buffer address width = log2(COLS*ROWS)
- BLANK, 8'h20, fill character for erased cells

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- mem_slot  in  1  high on cycles whose closing clk edge the RAM consumes the presented access (every other cycle)
- op_valid  in  1  bulk operation request
- op_ready  out  1  op accepted on clk edge where op_valid&&op_ready
- op_code  in  2  0 clear screen, 1 erase EOL, 2 erase EOS, 3 scroll up
- op_x  in  6  start column (codes 1,2)
- op_y  in  4  start row (codes 1,2)
- op_done  out  1  one-cycle pulse when an op completes
- hw_valid  in  1  single char write request
- hw_ready  out  1  write accepted on edge where hw_valid&&hw_ready
- hw_addr  in  ADDR_W  single write address (y*COLS+x)
- hw_data  in  8  single write char
- busy  out  1  high while any bulk op is in progress
- mem_en  out  1  access presented
- mem_we  out  1  1 write, 0 read
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data: valid from cycle after consuming edge, held until next consumed read

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-op aborts immediately with no op_done. Buffer contents are then undefined.
- mem_* are registered. An access is consumed at an edge with mem_en&&mem_slot. On that same edge the block loads the next access or clears mem_en. With mem_en=0, mem_slot is ignored.
- hw_ready = IDLE && (!mem_en || mem_slot). An accepted hw write loads mem_en=1, we=1, addr=hw_addr, wdata=hw_data.
- op_ready = IDLE && (!mem_en || mem_slot) && !hw_valid. A host write wins over a simultaneous op; the op waits.
- On op accept: busy=1 on the next cycle and stays high until the op_done cycle inclusive.
- Op ranges, base = op_y*COLS:
  - code 0: FILL 0..COLS*ROWS-1.
  - code 1: FILL base+op_x..base+COLS-1.
  - code 2: FILL base+op_x..COLS*ROWS-1.
  - code 3: COPY, then FILL (ROWS-1)*COLS..COLS*ROWS-1.
- op_y>=ROWS or op_x>=COLS on codes 1/2: no memory access; op_done one cycle after accept.
- FILL: one write of BLANK per consumed slot, ascending address. First access is loaded on the accept edge.
- COPY, for src = COLS..COLS*ROWS-1 ascending:
  - RD state presents read(src).
  - At its consuming edge go to WR.
  - WR presents write(src-COLS, mem_rdata sampled at the WR load edge, i.e. cycle after the read's consumption).
  - Strict alternation. Exactly 2*(ROWS-1)*COLS copy slots.
- Last access consumed -> mem_en=0, op_done=1 for one cycle, return to IDLE. A new request is accepted at the earliest on the edge after op_done.
- Slot counts (defaults): code 0 = 1024, code 3 = 1984, code 1 at x=60 = 4.
- Address counters are ADDR_W wide. The end address is compared inclusively; no wrap past COLS*ROWS-1.
- No host writes are accepted while busy (hw_ready=0), so the buffer is never observed mid-scroll.

Test Plan:
- Reset mid-scroll: after 100 slots assert clr -> mem_en=0, busy=0, op_ready=1 next cycle, no op_done.
- Clear screen with mem_slot toggling:
  - Expected: writes 0x20 to addr 0..1023 in order, exactly 1024 writes.
  - Expected: op_done single pulse after the write to 1023; busy high throughout.
- Erase EOL, op_y=3, op_x=60 -> writes at 252..255 only. op_x=64 equivalent (x>=COLS) -> zero accesses, op_done one cycle after accept.
- Scroll up with buffer preloaded addr→addr[7:0]:
  - First accesses: read 64, write 0 data 0x40.
  - After completion: row r holds old row r+1 for r<15; row 15 all 0x20.
  - Total 1984 consumed slots.
- Arbitration:
  - hw_valid and op_valid same cycle in IDLE -> write (addr 5, 'A') accepted first, op accepted on a later edge.
  - hw_valid during scroll -> hw_ready=0 until after op_done, then write accepted.
- Back-to-back hw writes -> one write per slot, hw_ready low on non-slot cycles while an access is pending.
